// File: rtl/div_16_if.sv
// Handshake and operand/result bundle between the control unit and div_16.
interface div_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_16.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// results registered on completion with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | shift-subtract iterations running (busy)
// FIN   | results valid for one cycle (done); start here chains the next op
module div_16 #(
    parameter int WIDTH = 16
) (
    input  logic    clk,
    input  logic    rst,
    div_16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_raw_q;
    logic             q_neg_q, r_neg_q, dbz_cap_q;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q;

    logic             busy, done, accept, last;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIN;
                    last    = 1'b1;
                end
            end
            FIN: begin
                done = 1'b1;
                if (bus.start) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
        dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
        dvd_mag = dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        dvs_mag = dvs_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
    end

    // Trial subtraction on the shifted partial remainder; restore when it would go negative.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = (shifted >= {2'b00, dvs_q});
        diff    = shifted[WIDTH:0] - {1'b0, dvs_q};
        rem_d   = ge ? diff : shifted[WIDTH:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
    end

    always_comb begin
        quotient_d  = q_neg_q ? (~quo_d + WIDTH'(1)) : quo_d;
        remainder_d = r_neg_q ? (~rem_d[WIDTH-1:0] + WIDTH'(1)) : rem_d[WIDTH-1:0];
        if (dbz_cap_q) begin
            quotient_d  = '1;
            remainder_d = dvd_raw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            dvd_raw_q     <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_cap_q     <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q     <= '0;
                rem_q     <= '0;
                quo_q     <= dvd_mag;
                dvs_q     <= dvs_mag;
                dvd_raw_q <= bus.dividend;
                q_neg_q   <= dvd_neg ^ dvs_neg;
                r_neg_q   <= dvd_neg;
                dbz_cap_q <= (bus.divisor == '0);
            end else if (busy) begin
                cnt_q <= cnt_q + CW'(1);
                rem_q <= rem_d;
                quo_q <= quo_d;
                if (last) begin
                    quotient_q    <= quotient_d;
                    remainder_q   <= remainder_d;
                    div_by_zero_q <= dbz_cap_q;
                end
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule
